fetch_ctrl: RTL and testbench

//  Y86-64 fetch sequencer. Owns the PC and drives the combinational instruction memory.

---
 rtl/fetch_ctrl.sv | 97 +++++++++
 tb/tb_fetch_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: Y86-64 fetch sequencer with next-PC prediction, ret stall, redirect and status reporting
module fetch_ctrl #(
  parameter int DATA_WID = 64,
  parameter int MEM_BYTES = 2048,
  parameter logic [DATA_WID-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [DATA_WID-1:0] imem_pc,
  input  logic [3:0]          imem_icode,
  input  logic [3:0]          imem_ifun,
  input  logic [3:0]          imem_rA,
  input  logic [3:0]          imem_rB,
  input  logic [DATA_WID-1:0] imem_valC,
  input  logic                redirect_valid,
  input  logic [DATA_WID-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_icode,
  output logic [3:0]          out_ifun,
  output logic [3:0]          out_rA,
  output logic [3:0]          out_rB,
  output logic [DATA_WID-1:0] out_valC,
  output logic [DATA_WID-1:0] out_valP,
  output logic [DATA_WID-1:0] out_pc,
  output logic [2:0]          stat
);
  typedef enum logic [1:0] {RUN, WAIT_RET, HALTED, ERR} state_t;
  state_t state, state_nxt;
  logic [DATA_WID-1:0] pc, pc_nxt, val_p;
  logic [2:0] stat_nxt;
  logic [3:0] len;
  logic inv, adr, fetch, emit;
  assign imem_pc = pc;
  assign len = imem_icode inside {4'h0, 4'h1, 4'h9} ? 4'd1 :
               imem_icode inside {4'h2, 4'h6, 4'hA, 4'hB} ? 4'd2 :
               imem_icode inside {4'h7, 4'h8} ? 4'd9 : 4'd10;
  assign inv = imem_icode > 4'hB;
  assign val_p = pc + DATA_WID'(len);
  // range check one bit wider so a PC near the top of the address space cannot wrap past it
  assign adr = ({1'b0, pc} + (DATA_WID+1)'(len)) > (DATA_WID+1)'(MEM_BYTES);
  assign fetch = state == RUN && (!out_valid || out_ready) && !redirect_valid;
  assign emit = fetch && !inv && !adr;
  always_comb begin
    state_nxt = state;
    pc_nxt = pc;
    stat_nxt = stat;
    if (redirect_valid) begin
      state_nxt = RUN;
      pc_nxt = redirect_pc;
      stat_nxt = 3'd1;
    end else if (fetch) begin
      if (inv || adr) begin
        state_nxt = ERR;
        stat_nxt = inv ? 3'd4 : 3'd3;
      end else if (imem_icode == 4'h7 || imem_icode == 4'h8) begin
        pc_nxt = imem_valC;
      end else if (imem_icode == 4'h9) begin
        state_nxt = WAIT_RET;
      end else if (imem_icode == 4'h0) begin
        state_nxt = HALTED;
        stat_nxt = 3'd2;
      end else begin
        pc_nxt = val_p;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
      stat <= 3'd1;
      out_valid <= 1'b0;
      out_icode <= '0;
      out_ifun <= '0;
      out_rA <= '0;
      out_rB <= '0;
      out_valC <= '0;
      out_valP <= '0;
      out_pc <= '0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      stat <= stat_nxt;
      out_valid <= redirect_valid ? 1'b0 : emit ? 1'b1 : out_ready ? 1'b0 : out_valid;
      if (emit) begin
        out_icode <= imem_icode;
        out_ifun <= imem_ifun;
        out_rA <= imem_rA;
        out_rB <= imem_rB;
        out_valC <= imem_valC;
        out_valP <= val_p;
        out_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic checked against an instruction-level model
module tb_fetch_ctrl;
  localparam int MEMB = 2048;
  localparam int M_RUN = 0, M_RET = 1, M_HLT = 2, M_ERR = 3;
  logic clk = 0, rst = 0;
  logic [63:0] imem_pc, imem_valC, redirect_pc, out_valC, out_valP, out_pc;
  logic [3:0] imem_icode, imem_ifun, imem_rA, imem_rB, out_icode, out_ifun, out_rA, out_rB;
  logic redirect_valid = 0, out_valid, out_ready = 0;
  logic [2:0] stat;
  int total = 0, bad = 0;
  logic [7:0] mem [MEMB+16];
  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};
  logic [63:0] m_pc, m_valc, m_valp, m_opc;
  logic [3:0] m_icode, m_ifun, m_ra, m_rb;
  logic [2:0] m_stat;
  logic m_valid;
  int m_mode;

  fetch_ctrl #(.DATA_WID(64), .MEM_BYTES(MEMB), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_icode(imem_icode), .imem_ifun(imem_ifun),
    .imem_rA(imem_rA), .imem_rB(imem_rB), .imem_valC(imem_valC),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode), .out_ifun(out_ifun),
    .out_rA(out_rA), .out_rB(out_rB), .out_valC(out_valC), .out_valP(out_valP),
    .out_pc(out_pc), .stat(stat));

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return (a < 64'(MEMB + 16)) ? mem[int'(a)] : 8'h00;
  endfunction

  function automatic logic [63:0] word(input logic [63:0] a);
    logic [63:0] w = '0;
    for (int i = 7; i >= 0; i--) w = {w[55:0], rd(a + 64'(i))};
    return w;
  endfunction

  function automatic logic [63:0] valc_at(input logic [63:0] a);
    logic [7:0] b = rd(a);
    return (b[7:4] == 4'h7 || b[7:4] == 4'h8) ? word(a + 1) : word(a + 2);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic rdy, input logic rv, input logic [63:0] rpc);
    logic [7:0] b, b2;
    bit load = 0;
    if (r) begin
      m_pc = 0; m_mode = M_RUN; m_stat = 1; m_valid = 0;
      m_icode = 0; m_ifun = 0; m_ra = 0; m_rb = 0; m_valc = 0; m_valp = 0; m_opc = 0;
    end else if (rv) begin
      m_pc = rpc; m_mode = M_RUN; m_stat = 1; m_valid = 0;
    end else begin
      if (m_mode == M_RUN && (!m_valid || rdy)) begin
        b = rd(m_pc);
        if (b[7:4] > 4'hB) begin
          m_mode = M_ERR; m_stat = 4;
        end else if (m_pc + 64'(len_tab[b[7:4]]) > 64'(MEMB)) begin
          m_mode = M_ERR; m_stat = 3;
        end else begin
          load = 1; b2 = rd(m_pc + 1);
          m_valid = 1; m_icode = b[7:4]; m_ifun = b[3:0]; m_ra = b2[7:4]; m_rb = b2[3:0];
          m_valc = valc_at(m_pc); m_valp = m_pc + 64'(len_tab[b[7:4]]); m_opc = m_pc;
          if (m_icode == 7 || m_icode == 8) m_pc = m_valc;
          else if (m_icode == 9) m_mode = M_RET;
          else if (m_icode == 0) begin m_mode = M_HLT; m_stat = 2; end
          else m_pc = m_valp;
        end
      end
      if (!load && rdy) m_valid = 0;
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic rv = 0, input logic [63:0] rpc = 0);
    logic [7:0] b, b2;
    rst = r; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    b = rd(imem_pc); b2 = rd(imem_pc + 1);
    imem_icode = b[7:4]; imem_ifun = b[3:0]; imem_rA = b2[7:4]; imem_rB = b2[3:0];
    imem_valC = valc_at(imem_pc);
    model(r, rdy, rv, rpc);
    @(posedge clk);
    @(negedge clk);
    chk("pc", imem_pc, m_pc);
    chk("valid", 64'(out_valid), 64'(m_valid));
    chk("stat", 64'(stat), 64'(m_stat));
    chk("fields", {out_icode, out_ifun, out_rA, out_rB}, {m_icode, m_ifun, m_ra, m_rb});
    chk("valc", out_valC, m_valc);
    chk("valp", out_valP, m_valp);
    chk("out_pc", out_pc, m_opc);
  endtask

  task automatic fill_nops();
    for (int i = 0; i < MEMB + 16; i++) mem[i] = 8'h10;
  endtask

  initial begin
    fill_nops();
    @(negedge clk);
    // sequential fetch
    {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h10, 8'h20, 8'h12, 8'h30, 8'hF3};
    for (int i = 0; i < 8; i++) mem[5 + i] = 8'(8'h11 * (i + 1));
    step(1, 1);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_stat", 64'(stat), 1);
    step(0, 1); chk("t1_valp0", out_valP, 64'h1);
    step(0, 1); chk("t1_valp1", out_valP, 64'h3);
    step(0, 1); chk("t1_valp3", out_valP, 64'hD);
    chk("t1_valc", out_valC, 64'h8877665544332211);
    // backpressure
    step(1, 1); step(0, 1);
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("t2_hold", out_pc, 64'h0);
    step(0, 1); chk("t2_resume", out_pc, 64'h1);
    step(0, 1);
    // jump prediction and redirect flush
    fill_nops();
    mem[0] = 8'h70;
    for (int i = 0; i < 8; i++) mem[1 + i] = (i == 0) ? 8'h40 : 8'h00;
    step(1, 1);
    step(0, 1); chk("t3_valp", out_valP, 64'h9);
    step(0, 1, 1, 64'h20); chk("t3_flush", 64'(out_valid), 0);
    step(0, 1); chk("t3_redir", out_pc, 64'h20);
    // ret stall
    fill_nops();
    mem[5] = 8'h90;
    step(1, 1);
    for (int i = 0; i < 6; i++) step(0, 1);
    chk("t4_ret", 64'(out_icode), 64'h9);
    for (int i = 0; i < 4; i++) step(0, 1);
    chk("t4_stall", 64'(out_valid), 0);
    step(0, 1, 1, 64'h80);
    step(0, 1); chk("t4_fetch", out_pc, 64'h80);
    // faults
    fill_nops();
    mem[0] = 8'hC0; mem[MEMB-5] = 8'h30;
    step(1, 1);
    step(0, 1); chk("t5_ins", 64'(stat), 4);
    step(0, 1, 1, 64'(MEMB - 5)); chk("t5_clr", 64'(stat), 1);
    step(0, 1); chk("t5_adr", 64'(stat), 3);
    mem[0] = 8'h10;
    step(0, 1, 1, 64'h0);
    step(0, 1); chk("t5_resume", 64'(out_valid), 1);
    // halt then reset
    mem[2] = 8'h00;
    step(1, 1);
    for (int i = 0; i < 3; i++) step(0, 1);
    chk("t6_halt_pc", out_pc, 64'h2);
    chk("t6_hlt", 64'(stat), 2);
    step(0, 1);
    step(1, 0); chk("t6_rst", 64'(stat), 1);
    // randomized traffic
    for (int i = 0; i < MEMB + 16; i++) begin
      int r = $urandom_range(0, 99);
      logic [3:0] ic = r < 3 ? 4'h0 : r < 7 ? 4'($urandom_range(12, 15)) : 4'($urandom_range(1, 11));
      mem[i] = {ic, 4'($urandom)};
    end
    step(1, 1);
    for (int i = 0; i < 3000; i++)
      step(($urandom % 200) == 0, ($urandom % 4) != 0, ($urandom % 12) == 0, 64'($urandom_range(0, MEMB + 8)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
